// File: rtl/gdsp_clk_mgr_if.sv
// gdsp_clk_mgr_if: bundle of lock, divide-ratio, enable and reset signals
// between the clock/reset manager (master) and the domains it serves (slave).
interface gdsp_clk_mgr_if #(
   parameter int N_CH  = 4,
   parameter int DIV_W = 8
);
   logic                    pll_lock_i;
   logic [N_CH*DIV_W-1:0]   div_i;
   logic [N_CH-1:0]         ce_o;
   logic [N_CH-1:0]         rst_o;
   logic                    locked_o;
   logic [1:0]              state_o;
   logic [7:0]              lock_loss_cnt_o;

   modport master (
      input  pll_lock_i, div_i,
      output ce_o, rst_o, locked_o, state_o, lock_loss_cnt_o
   );

   modport slave (
      output pll_lock_i, div_i,
      input  ce_o, rst_o, locked_o, state_o, lock_loss_cnt_o
   );
endinterface

// File: rtl/gdsp_clk_mgr.sv
// gdsp_clk_mgr: qualifies the raw PLL lock (2-flop sync + stability timer),
// releases per-channel resets in a staggered sequence and generates
// per-channel clock-enable strobes at captured integer divide ratios.
// Optional feature macro: GDSP_CLKMGR_LOSS_CNT_EN builds the saturating
// lock-loss counter; without it lock_loss_cnt_o is tied to zero.
module gdsp_clk_mgr #(
   parameter int N_CH            = 4,
   parameter int DIV_W           = 8,
   parameter int LOCK_STABLE_CYC = 1024,
   parameter int RST_STAGGER     = 16
) (
   input  logic          clk,
   input  logic          rst,
   gdsp_clk_mgr_if.master bus
);
   localparam logic [1:0] ST_WAIT    = 2'd0;
   localparam logic [1:0] ST_STABLE  = 2'd1;
   localparam logic [1:0] ST_RELEASE = 2'd2;
   localparam logic [1:0] ST_RUN     = 2'd3;

   // Stagger count at which the last channel is released.
   localparam int LAST_STAG = (N_CH - 1) * RST_STAGGER;
   localparam int SC_W      = $clog2(LAST_STAG + 2);
   localparam int STW       = $clog2(LOCK_STABLE_CYC + 1);

   logic            lock_meta_reg;
   logic            lock_s_reg;
   logic [1:0]      state_reg, state_next;
   logic [STW-1:0]  stable_cnt_reg, stable_cnt_next;
   logic [SC_W-1:0] stag_cnt_reg, stag_cnt_next;
   logic [N_CH-1:0] rst_reg, rst_next;
   logic            capture;
   logic [N_CH-1:0] ce;

   // Two-flop synchroniser for the asynchronous PLL lock.
   always_ff @(posedge clk) begin
      if (rst) begin
         lock_meta_reg <= 1'b0;
         lock_s_reg    <= 1'b0;
      end else begin
         lock_meta_reg <= bus.pll_lock_i;
         lock_s_reg    <= lock_meta_reg;
      end
   end

   // Next-state logic: lock qualification, staggered release, lock-loss fallback.
   always_comb begin
      state_next      = state_reg;
      stable_cnt_next = stable_cnt_reg;
      stag_cnt_next   = stag_cnt_reg;
      rst_next        = rst_reg;
      capture         = 1'b0;
      case (state_reg)
         ST_WAIT: begin
            rst_next = '1;
            if (lock_s_reg) begin
               state_next      = ST_STABLE;
               stable_cnt_next = '0;
            end
         end
         ST_STABLE: begin
            rst_next = '1;
            if (!lock_s_reg) begin
               state_next = ST_WAIT;
            end else if (stable_cnt_reg == STW'(LOCK_STABLE_CYC - 1)) begin
               // Channel 0 comes out of reset in the very first RELEASE cycle.
               state_next    = ST_RELEASE;
               stag_cnt_next = '0;
               capture       = 1'b1;
               for (int k = 0; k < N_CH; k++) begin
                  rst_next[k] = (k != 0);
               end
            end else begin
               stable_cnt_next = stable_cnt_reg + 1'b1;
            end
         end
         ST_RELEASE: begin
            // Lock loss has priority over any release boundary in this cycle.
            if (!lock_s_reg) begin
               state_next = ST_WAIT;
               rst_next   = '1;
            end else begin
               stag_cnt_next = stag_cnt_reg + 1'b1;
               for (int k = 0; k < N_CH; k++) begin
                  if ((int'(stag_cnt_reg) + 1) >= (k * RST_STAGGER)) begin
                     rst_next[k] = 1'b0;
                  end
               end
               if (stag_cnt_reg == SC_W'(LAST_STAG)) begin
                  state_next = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            rst_next = '0;
            if (!lock_s_reg) begin
               state_next = ST_WAIT;
               rst_next   = '1;
            end
         end
         default: begin
            state_next = ST_WAIT;
            rst_next   = '1;
         end
      endcase
   end

   // FSM state, counters and registered per-channel resets.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= ST_WAIT;
         stable_cnt_reg <= '0;
         stag_cnt_reg   <= '0;
         rst_reg        <= '1;
      end else begin
         state_reg      <= state_next;
         stable_cnt_reg <= stable_cnt_next;
         stag_cnt_reg   <= stag_cnt_next;
         rst_reg        <= rst_next;
      end
   end

   // Per-channel divider: ratio captured on RELEASE entry, counter held while in reset.
   genvar gi;
   generate
      for (gi = 0; gi < N_CH; gi++) begin : g_ch
         logic [DIV_W-1:0] cap_div_reg;
         logic [DIV_W-1:0] cnt_reg;
         logic             wrap;

         // Ratios 0 and 1 both mean "strobe every cycle".
         assign wrap = (cap_div_reg <= DIV_W'(1)) || (cnt_reg == cap_div_reg - 1'b1);

         // Capture the ratio and run the wrap counter.
         always_ff @(posedge clk) begin
            if (rst) begin
               cap_div_reg <= '0;
               cnt_reg     <= '0;
            end else begin
               if (capture) begin
                  cap_div_reg <= bus.div_i[gi*DIV_W +: DIV_W];
               end
               if (rst_reg[gi] || wrap) begin
                  cnt_reg <= '0;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
         end

         assign ce[gi] = !rst_reg[gi] && wrap;
      end
   endgenerate

`ifdef GDSP_CLKMGR_LOSS_CNT_EN
   logic       loss;
   logic [7:0] loss_cnt_reg;

   // Only a loss after release has started counts; a STABLE dropout does not.
   assign loss = !lock_s_reg && ((state_reg == ST_RELEASE) || (state_reg == ST_RUN));

   // Saturating lock-loss event counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         loss_cnt_reg <= 8'd0;
      end else if (loss && (loss_cnt_reg != 8'hFF)) begin
         loss_cnt_reg <= loss_cnt_reg + 8'd1;
      end
   end

   assign bus.lock_loss_cnt_o = loss_cnt_reg;
`else
   assign bus.lock_loss_cnt_o = 8'd0;
`endif

   assign bus.ce_o     = ce;
   assign bus.rst_o    = rst_reg;
   assign bus.state_o  = state_reg;
   assign bus.locked_o = (state_reg == ST_RUN);

endmodule
